iterative_alu: RTL and testbench

- Parametrised, multi-cycle successor to the combinational ALU.
- Single-cycle ops (add/sub/logic/shift/compare/conditional-select) complete in one cycle.
- MUL and DIV run as iterative shift-add and restoring-divide engines over WIDTH cycles.
- Sits between the decode/operand-fetch stage and writeback; valid/ready handshakes on both sides stall the pipeline around long operations.

---
 rtl/iterative_alu_pkg.sv | 42 ++++
 rtl/iterative_alu_if.sv | 47 ++++
 rtl/iterative_divider.sv | 77 +++++++
 rtl/iterative_alu.sv | 193 +++++++++++++++++++
 tb/tb_iterative_alu.sv | 322 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/iterative_alu_pkg.sv
// ============================================================================
// Module : iterative_alu_pkg
// Brief  : Shared ALU op codes and FSM state encoding for iterative_alu.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package iterative_alu_pkg;

    localparam int ALU_OP_W = 4;

    localparam logic [ALU_OP_W-1:0] ALU_ADD    = 4'd0;
    localparam logic [ALU_OP_W-1:0] ALU_SUB    = 4'd1;
    localparam logic [ALU_OP_W-1:0] ALU_MUL    = 4'd2;
    localparam logic [ALU_OP_W-1:0] ALU_DIV    = 4'd3;
    localparam logic [ALU_OP_W-1:0] ALU_AND    = 4'd4;
    localparam logic [ALU_OP_W-1:0] ALU_OR     = 4'd5;
    localparam logic [ALU_OP_W-1:0] ALU_NOR    = 4'd6;
    localparam logic [ALU_OP_W-1:0] ALU_XOR    = 4'd7;
    localparam logic [ALU_OP_W-1:0] ALU_SFL    = 4'd8;
    localparam logic [ALU_OP_W-1:0] ALU_SFR    = 4'd9;
    localparam logic [ALU_OP_W-1:0] ALU_SLT    = 4'd10;
    localparam logic [ALU_OP_W-1:0] ALU_SEQ    = 4'd11;
    localparam logic [ALU_OP_W-1:0] ALU_SNQ    = 4'd12;
    localparam logic [ALU_OP_W-1:0] ALU_SEQNEG = 4'd13;
    localparam logic [ALU_OP_W-1:0] ALU_SNQNEG = 4'd14;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } alu_state_t;

    function automatic logic is_cond_op(input logic [ALU_OP_W-1:0] op);
        return (op == ALU_SEQ) || (op == ALU_SNQ) ||
               (op == ALU_SEQNEG) || (op == ALU_SNQNEG);
    endfunction

endpackage

`default_nettype wire

// File: rtl/iterative_alu_if.sv
// ============================================================================
// Module : iterative_alu_if
// Brief  : Request/response handshake bundle; remainder exists only when
//          ITERATIVE_ALU_REMAINDER_EN is defined.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface iterative_alu_if #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 6,
    parameter int OP_W    = 4
);
    logic               in_valid;
    logic               in_ready;
    logic [OP_W-1:0]    operation;
    logic [WIDTH-1:0]   opA;
    logic [WIDTH-1:0]   opB;
    logic [WIDTH-1:0]   opC;
    logic [SHAMT_W-1:0] shamft;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   result;
    logic               div_by_zero;
`ifdef ITERATIVE_ALU_REMAINDER_EN
    logic [WIDTH-1:0]   remainder;
`endif

    modport master (
        output in_valid, operation, opA, opB, opC, shamft, out_ready,
        input  in_ready, out_valid, result, div_by_zero
`ifdef ITERATIVE_ALU_REMAINDER_EN
        , input remainder
`endif
    );

    modport slave (
        input  in_valid, operation, opA, opB, opC, shamft, out_ready,
        output in_ready, out_valid, result, div_by_zero
`ifdef ITERATIVE_ALU_REMAINDER_EN
        , output remainder
`endif
    );

endinterface

`default_nettype wire

// File: rtl/iterative_divider.sv
// ============================================================================
// Module : iterative_divider
// Brief  : Unsigned restoring divider, WIDTH iterations, first one on start.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module iterative_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int CNT_W = $clog2(WIDTH);

    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] dvs;
    logic [WIDTH-1:0] src_rem;
    logic [WIDTH-1:0] src_quo;
    logic [WIDTH-1:0] src_dvs;
    logic [WIDTH:0]   trial;
    logic [WIDTH:0]   diff;

    // The start cycle performs iteration one straight from the input operands,
    // so done rises after WIDTH edges counting the start edge.
    always_comb begin
        src_rem = start ? '0       : remainder;
        src_quo = start ? dividend : quotient;
        src_dvs = start ? divisor  : dvs;
        trial   = {src_rem, src_quo[WIDTH-1]};
        diff    = trial - {1'b0, src_dvs};
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            busy      <= 1'b0;
            done      <= 1'b0;
            cnt       <= '0;
            dvs       <= '0;
            quotient  <= '0;
            remainder <= '0;
        end else begin
            done <= 1'b0;
            if (start || busy) begin
                if (!diff[WIDTH]) begin
                    remainder <= diff[WIDTH-1:0];
                    quotient  <= {src_quo[WIDTH-2:0], 1'b1};
                end else begin
                    remainder <= trial[WIDTH-1:0];
                    quotient  <= {src_quo[WIDTH-2:0], 1'b0};
                end
            end
            if (start) begin
                busy <= 1'b1;
                cnt  <= CNT_W'(1);
                dvs  <= divisor;
            end else if (busy) begin
                cnt <= cnt + CNT_W'(1);
                if (cnt == CNT_W'(WIDTH-1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/iterative_alu.sv
// ============================================================================
// Module : iterative_alu
// Brief  : Multi-cycle ALU: 1-cycle simple ops, iterative MUL/DIV.
//          Optional remainder output via ITERATIVE_ALU_REMAINDER_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module iterative_alu
    import iterative_alu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 6,
    parameter int OP_W    = ALU_OP_W
) (
    input  logic          clock,
    input  logic          reset_n,
    iterative_alu_if.slave bus
);

    localparam int CNT_W = $clog2(WIDTH);

    alu_state_t         state;
    logic               ready_q;
    logic               valid_q;
    logic [WIDTH-1:0]   result_q;
    logic               dbz_q;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   acc;
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   mplier;
    logic [WIDTH-1:0]   acc_next;
    logic [SHAMT_W-1:0] sh;
    logic [OP_W-1:0]    op;
    logic               accept;
    logic [WIDTH-1:0]   simple_raw;
    logic [WIDTH-1:0]   simple_res;

    logic               div_start;
    logic               div_done;
    logic               div_busy_unused;
    logic [WIDTH-1:0]   div_quo;
    logic [WIDTH-1:0]   div_rem;

    function automatic logic [WIDTH-1:0] shl(input logic [WIDTH-1:0] v,
                                             input logic [SHAMT_W-1:0] s);
        if (int'(s) >= WIDTH) return '0;
        return v << s;
    endfunction

    assign op        = bus.operation;
    assign accept    = bus.in_valid && ready_q;
    assign div_start = accept && (op == ALU_DIV) && (bus.opB != '0);
    assign acc_next  = acc + (mplier[0] ? mcand : '0);

    always_comb begin
        simple_raw = '0;
        case (op)
            ALU_ADD: simple_raw = bus.opA + bus.opB;
            ALU_SUB: simple_raw = bus.opA - bus.opB;
            ALU_AND: simple_raw = bus.opA & bus.opB;
            ALU_OR:  simple_raw = bus.opA | bus.opB;
            ALU_NOR: simple_raw = ~(bus.opA | bus.opB);
            ALU_XOR: simple_raw = bus.opA ^ bus.opB;
            ALU_SFL: simple_raw = (bus.opB >= WIDTH'(WIDTH)) ? '0 : bus.opA << bus.opB;
            ALU_SFR: simple_raw = (bus.opB >= WIDTH'(WIDTH)) ? '0 : bus.opA >> bus.opB;
            ALU_SLT: simple_raw = {{(WIDTH-1){1'b0}}, (bus.opA < bus.opB)};
            default: simple_raw = '0;
        endcase

        simple_res = shl(simple_raw, bus.shamft);
        // Conditional selects bypass the post-shift entirely.
        if (is_cond_op(op)) begin
            case (op)
                ALU_SEQ:    simple_res = (bus.opC == bus.opA) ? bus.opB  : WIDTH'(1);
                ALU_SNQ:    simple_res = (bus.opC != bus.opA) ? bus.opB  : WIDTH'(1);
                ALU_SEQNEG: simple_res = (bus.opC == bus.opA) ? -bus.opB : WIDTH'(1);
                default:    simple_res = (bus.opC != bus.opA) ? -bus.opB : WIDTH'(1);
            endcase
        end
    end

    iterative_divider #(.WIDTH(WIDTH)) u_divider (
        .clock     (clock),
        .reset_n   (reset_n),
        .start     (div_start),
        .dividend  (bus.opA),
        .divisor   (bus.opB),
        .busy      (div_busy_unused),
        .done      (div_done),
        .quotient  (div_quo),
        .remainder (div_rem)
    );

`ifdef ITERATIVE_ALU_REMAINDER_EN
    logic [WIDTH-1:0] rem_q;
    assign bus.remainder = rem_q;
`else
    logic div_rem_unused;
    assign div_rem_unused = ^div_rem;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            ready_q  <= 1'b0;
            valid_q  <= 1'b0;
            result_q <= '0;
            dbz_q    <= 1'b0;
            cnt      <= '0;
            acc      <= '0;
            mcand    <= '0;
            mplier   <= '0;
            sh       <= '0;
`ifdef ITERATIVE_ALU_REMAINDER_EN
            rem_q    <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    ready_q <= 1'b1;
                    if (accept) begin
                        ready_q <= 1'b0;
                        dbz_q   <= 1'b0;
                        sh      <= bus.shamft;
                        cnt     <= '0;
`ifdef ITERATIVE_ALU_REMAINDER_EN
                        rem_q   <= '0;
`endif
                        if (op == ALU_MUL) begin
                            acc    <= '0;
                            mcand  <= bus.opA;
                            mplier <= bus.opB;
                            state  <= ST_MUL;
                        end else if (op == ALU_DIV && bus.opB == '0) begin
                            result_q <= shl('1, bus.shamft);
                            dbz_q    <= 1'b1;
                            valid_q  <= 1'b1;
                            state    <= ST_DONE;
`ifdef ITERATIVE_ALU_REMAINDER_EN
                            rem_q    <= bus.opA;
`endif
                        end else if (op == ALU_DIV) begin
                            state <= ST_DIV;
                        end else begin
                            result_q <= simple_res;
                            valid_q  <= 1'b1;
                            state    <= ST_DONE;
                        end
                    end
                end
                ST_MUL: begin
                    // Shift-add: one multiplier bit per cycle, last one folded into the result.
                    acc    <= acc_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(WIDTH-1)) begin
                        result_q <= shl(acc_next, sh);
                        valid_q  <= 1'b1;
                        state    <= ST_DONE;
                    end
                end
                ST_DIV: begin
                    if (div_done) begin
                        result_q <= shl(div_quo, sh);
                        valid_q  <= 1'b1;
                        state    <= ST_DONE;
`ifdef ITERATIVE_ALU_REMAINDER_EN
                        rem_q    <= div_rem;
`endif
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        valid_q <= 1'b0;
                        ready_q <= 1'b1;
                        state   <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.in_ready    = ready_q;
    assign bus.out_valid   = valid_q;
    assign bus.result      = result_q;
    assign bus.div_by_zero = dbz_q;

endmodule

`default_nettype wire

// File: tb/tb_iterative_alu.sv
// ============================================================================
// Module : tb_iterative_alu
// Brief  : Directed self-checking bench for iterative_alu (WIDTH=32).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_iterative_alu;
    import iterative_alu_pkg::*;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    iterative_alu_if #(.WIDTH(32), .SHAMT_W(6), .OP_W(4)) bus ();

    iterative_alu #(.WIDTH(32), .SHAMT_W(6), .OP_W(4)) dut (
        .clock   (clk),
        .reset_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive a request, wait for accept, then wait for out_valid.
    // lat counts edges from the accept edge (inclusive) to out_valid.
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] c, input logic [5:0] s, output int lat);
        int n;
        bus.operation = op;
        bus.opA       = a;
        bus.opB       = b;
        bus.opC       = c;
        bus.shamft    = s;
        bus.in_valid  = 1'b1;
        n = 0;
        while (!bus.in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (n >= 100) begin
            errors++;
            $display("FAIL ready_timeout in_ready got %b want 1", bus.in_ready);
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic retire();
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got %b want 0", bus.in_ready); end
        checks++;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b want 0", bus.out_valid); end
        checks++;
        if (bus.result !== 32'h0) begin errors++; $display("FAIL rst_result got %h want 0", bus.result); end
        checks++;
        if (bus.div_by_zero !== 1'b0) begin errors++; $display("FAIL rst_dbz got %b want 0", bus.div_by_zero); end
        rst_n = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL rel_in_ready_early got %b want 0", bus.in_ready); end
        @(posedge clk); #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rel_in_ready got %b want 1", bus.in_ready); end
    endtask

    task automatic test_add();
        int lat;
        run_op(ALU_ADD, 32'd5, 32'd3, 32'd0, 6'd1, lat);
        checks++;
        if (lat !== 1) begin errors++; $display("FAIL add_latency got %0d want 1", lat); end
        checks++;
        if (bus.result !== 32'd16) begin errors++; $display("FAIL add_result got %h want 00000010", bus.result); end
        checks++;
        if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL add_busy_ready got %b want 0", bus.in_ready); end
        retire();
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL add_retire got valid=%b ready=%b want valid=0 ready=1", bus.out_valid, bus.in_ready);
        end
    endtask

    task automatic test_simple_ops();
        int lat;
        run_op(ALU_SUB, 32'd3, 32'd5, 32'd0, 6'd0, lat);
        checks++;
        if (bus.result !== 32'hFFFF_FFFE) begin errors++; $display("FAIL sub_wrap got %h want fffffffe", bus.result); end
        retire();
        run_op(ALU_AND, 32'h0000_F0F0, 32'h0000_FF00, 32'd0, 6'd0, lat);
        checks++;
        if (bus.result !== 32'h0000_F000) begin errors++; $display("FAIL and got %h want 0000f000", bus.result); end
        retire();
        run_op(ALU_SFL, 32'd1, 32'd32, 32'd0, 6'd0, lat);
        checks++;
        if (bus.result !== 32'h0) begin errors++; $display("FAIL sfl_big_amount got %h want 0", bus.result); end
        retire();
        run_op(ALU_SFR, 32'h80, 32'd3, 32'd0, 6'd1, lat);
        checks++;
        if (bus.result !== 32'h20) begin errors++; $display("FAIL sfr_shift got %h want 00000020", bus.result); end
        retire();
        run_op(ALU_SLT, 32'd2, 32'd3, 32'd0, 6'd4, lat);
        checks++;
        if (bus.result !== 32'h10) begin errors++; $display("FAIL slt_true got %h want 00000010", bus.result); end
        retire();
        run_op(ALU_NOR, 32'd0, 32'd0, 32'd0, 6'd40, lat);
        checks++;
        if (bus.result !== 32'h0) begin errors++; $display("FAIL nor_big_shamft got %h want 0", bus.result); end
        retire();
        run_op(ALU_ADD, 32'd1, 32'd0, 32'd0, 6'd31, lat);
        checks++;
        if (bus.result !== 32'h8000_0000) begin errors++; $display("FAIL add_shamft31 got %h want 80000000", bus.result); end
        retire();
        run_op(4'd15, 32'd7, 32'd7, 32'd7, 6'd0, lat);
        checks++;
        if (bus.result !== 32'h0 || lat !== 1) begin
            errors++; $display("FAIL undef_op got %h lat %0d want 0 lat 1", bus.result, lat);
        end
        retire();
    endtask

    task automatic test_mul();
        int lat;
        run_op(ALU_MUL, 32'd7, 32'd6, 32'd0, 6'd0, lat);
        checks++;
        if (lat !== 33) begin errors++; $display("FAIL mul_latency got %0d want 33", lat); end
        checks++;
        if (bus.result !== 32'd42) begin errors++; $display("FAIL mul_result got %h want 0000002a", bus.result); end
        retire();
        run_op(ALU_MUL, 32'hFFFF_FFFF, 32'd2, 32'd0, 6'd0, lat);
        checks++;
        if (bus.result !== 32'hFFFF_FFFE) begin errors++; $display("FAIL mul_wrap got %h want fffffffe", bus.result); end
        retire();
        run_op(ALU_MUL, 32'd3, 32'd5, 32'd0, 6'd2, lat);
        checks++;
        if (bus.result !== 32'd60) begin errors++; $display("FAIL mul_shift got %h want 0000003c", bus.result); end
        retire();
    endtask

    task automatic test_div();
        int lat;
        run_op(ALU_DIV, 32'd100, 32'd7, 32'd0, 6'd0, lat);
        checks++;
        if (lat !== 33) begin errors++; $display("FAIL div_latency got %0d want 33", lat); end
        checks++;
        if (bus.result !== 32'd14 || bus.div_by_zero !== 1'b0) begin
            errors++; $display("FAIL div_result got %h dbz %b want 0000000e dbz 0", bus.result, bus.div_by_zero);
        end
`ifdef ITERATIVE_ALU_REMAINDER_EN
        checks++;
        if (bus.remainder !== 32'd2) begin errors++; $display("FAIL div_remainder got %h want 00000002", bus.remainder); end
`endif
        retire();
        run_op(ALU_DIV, 32'd9, 32'd0, 32'd0, 6'd0, lat);
        checks++;
        if (lat !== 1) begin errors++; $display("FAIL dbz_latency got %0d want 1", lat); end
        checks++;
        if (bus.result !== 32'hFFFF_FFFF || bus.div_by_zero !== 1'b1) begin
            errors++; $display("FAIL dbz_result got %h dbz %b want ffffffff dbz 1", bus.result, bus.div_by_zero);
        end
`ifdef ITERATIVE_ALU_REMAINDER_EN
        checks++;
        if (bus.remainder !== 32'd9) begin errors++; $display("FAIL dbz_remainder got %h want 00000009", bus.remainder); end
`endif
        retire();
        run_op(ALU_ADD, 32'd1, 32'd2, 32'd0, 6'd0, lat);
        checks++;
        if (bus.div_by_zero !== 1'b0 || bus.result !== 32'd3) begin
            errors++; $display("FAIL dbz_clear got dbz %b result %h want dbz 0 result 00000003", bus.div_by_zero, bus.result);
        end
        retire();
    endtask

    task automatic test_cond();
        int lat;
        run_op(ALU_SEQNEG, 32'd4, 32'd3, 32'd4, 6'd5, lat);
        checks++;
        if (bus.result !== 32'hFFFF_FFFD) begin errors++; $display("FAIL seqneg got %h want fffffffd", bus.result); end
        retire();
        run_op(ALU_SNQ, 32'd4, 32'd3, 32'd4, 6'd0, lat);
        checks++;
        if (bus.result !== 32'd1) begin errors++; $display("FAIL snq_equal got %h want 00000001", bus.result); end
        retire();
        run_op(ALU_SEQ, 32'd4, 32'd9, 32'd5, 6'd0, lat);
        checks++;
        if (bus.result !== 32'd1) begin errors++; $display("FAIL seq_noteq got %h want 00000001", bus.result); end
        retire();
        run_op(ALU_SEQ, 32'd4, 32'd9, 32'd4, 6'd3, lat);
        checks++;
        if (bus.result !== 32'd9) begin errors++; $display("FAIL seq_equal got %h want 00000009", bus.result); end
        retire();
        run_op(ALU_SNQNEG, 32'd4, 32'd1, 32'd5, 6'd0, lat);
        checks++;
        if (bus.result !== 32'hFFFF_FFFF) begin errors++; $display("FAIL snqneg got %h want ffffffff", bus.result); end
        retire();
    endtask

    task automatic test_backpressure();
        int lat;
        run_op(ALU_ADD, 32'd2, 32'd2, 32'd0, 6'd0, lat);
        bus.operation = ALU_ADD;
        bus.opA       = 32'd9;
        bus.opB       = 32'd9;
        bus.shamft    = 6'd0;
        bus.in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++;
            if (bus.out_valid !== 1'b1 || bus.result !== 32'd4 || bus.in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold cycle %0d got valid=%b result=%h ready=%b want valid=1 result=00000004 ready=0",
                         i, bus.out_valid, bus.result, bus.in_ready);
            end
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL bp_release got valid=%b ready=%b want valid=0 ready=1", bus.out_valid, bus.in_ready);
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b1 || bus.result !== 32'd18) begin
            errors++; $display("FAIL bp_held_request got valid=%b result=%h want valid=1 result=00000012", bus.out_valid, bus.result);
        end
        retire();
    endtask

    task automatic test_reset_mid_div();
        int  lat;
        int  n;
        bit  seen;
        bus.operation = ALU_DIV;
        bus.opA       = 32'd1000;
        bus.opB       = 32'd3;
        bus.shamft    = 6'd0;
        bus.in_valid  = 1'b1;
        n = 0;
        while (!bus.in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.result !== 32'h0 || bus.in_ready !== 1'b0) begin
            errors++; $display("FAIL midrst_state got valid=%b result=%h ready=%b want 0 0 0", bus.out_valid, bus.result, bus.in_ready);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready got %b want 1", bus.in_ready); end
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (bus.out_valid) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin errors++; $display("FAIL midrst_no_partial got out_valid seen=%b want 0", seen); end
        run_op(ALU_ADD, 32'd1, 32'd1, 32'd0, 6'd0, lat);
        checks++;
        if (bus.result !== 32'd2 || lat !== 1) begin
            errors++; $display("FAIL midrst_add got %h lat %0d want 00000002 lat 1", bus.result, lat);
        end
        retire();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        checks        = 0;
        errors        = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.operation = '0;
        bus.opA       = '0;
        bus.opB       = '0;
        bus.opC       = '0;
        bus.shamft    = '0;
        test_reset();
        test_add();
        test_simple_ops();
        test_mul();
        test_div();
        test_cond();
        test_backpressure();
        test_reset_mid_div();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
